// File: rtl/rc6_pix_packer.sv
// Packs an 8-bit valid/ready pixel stream into 128-bit blocks for the RC6 core.
// Issues one block at a time and waits for the core to finish it before packing the next.
module rc6_pix_packer #(
  parameter logic [7:0] PAD_BYTE = 8'h00,
  parameter int         CNT_W    = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_key_ok,
  input  logic [7:0]       i_pix,
  input  logic             i_pix_valid,
  input  logic             i_pix_last,
  output logic             o_pix_ready,
  output logic [127:0]     o_din,
  output logic             o_din_en,
  input  logic             i_dout_en,
  output logic [4:0]       o_pad_cnt,
  output logic [CNT_W-1:0] o_blk_cnt,
  output logic             o_busy,
  output logic             o_err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_WAIT  = 2'd3
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [3:0]       k_q;
  logic [127:0]     din_q;
  logic [4:0]       pad_q;
  logic [CNT_W-1:0] blk_q;
  logic             err_q;

  logic beat;
  logic blk_done;

  assign beat     = i_pix_valid & o_pix_ready;
  assign blk_done = beat & ((k_q == 4'd15) | i_pix_last);

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (i_key_ok) state_d = ST_FILL;
      ST_FILL:  if (blk_done) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (i_dout_en) state_d = ST_FILL;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; ready also drops while key expansion is not done
  always_comb begin
    o_pix_ready = (state_q == ST_FILL) & i_key_ok;
    o_din_en    = (state_q == ST_ISSUE);
    o_busy      = (state_q == ST_WAIT);
  end

  // Byte packing, padding, counters and sticky error
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      k_q   <= 4'd0;
      din_q <= '0;
      pad_q <= 5'd0;
      blk_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (i_dout_en && (state_q != ST_WAIT)) begin
        err_q <= 1'b1;
      end
      if (beat) begin
        for (int j = 0; j < 16; j++) begin
          if (4'(j) == k_q) begin
            din_q[127-8*j -: 8] <= i_pix;
          end else if (blk_done && (4'(j) > k_q)) begin
            din_q[127-8*j -: 8] <= PAD_BYTE;
          end
        end
        // k restarts at 0 for the block packed after the core releases us
        k_q <= blk_done ? 4'd0 : k_q + 4'd1;
        if (blk_done) begin
          pad_q <= 5'd15 - {1'b0, k_q};
        end
      end
      if (state_q == ST_ISSUE) begin
        blk_q <= blk_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign o_din     = din_q;
  assign o_pad_cnt = pad_q;
  assign o_blk_cnt = blk_q;
  assign o_err     = err_q;

endmodule

// File: tb/tb_rc6_pix_packer.sv
// Bench for rc6_pix_packer: byte-queue reference model checked every cycle,
// plus directed scenarios with literal expected blocks.
module tb_rc6_pix_packer;

  logic         clk = 1'b0;
  logic         rst;
  logic         key_ok;
  logic [7:0]   pix;
  logic         pix_valid;
  logic         pix_last;
  logic         pix_ready;
  logic [127:0] din;
  logic         din_en;
  logic         dout_en;
  logic [4:0]   pad_cnt;
  logic [31:0]  blk_cnt;
  logic         busy;
  logic         err;

  always #5 clk = ~clk;

  rc6_pix_packer #(.PAD_BYTE(8'h00), .CNT_W(32)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_key_ok    (key_ok),
    .i_pix       (pix),
    .i_pix_valid (pix_valid),
    .i_pix_last  (pix_last),
    .o_pix_ready (pix_ready),
    .o_din       (din),
    .o_din_en    (din_en),
    .i_dout_en   (dout_en),
    .o_pad_cnt   (pad_cnt),
    .o_blk_cnt   (blk_cnt),
    .o_busy      (busy),
    .o_err       (err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference model: accepted bytes collect in a queue; a full or last-tagged
  // group becomes one block that is issued, then held until the core releases it.
  bit           chk_en = 1'b0;
  bit           seen_key, issue_now, outstanding, exp_err, prev_en;
  logic [7:0]   bq[$];
  logic [127:0] exp_block;
  logic [4:0]   exp_pad;
  logic [31:0]  exp_blk;

  always @(posedge clk) begin
    if (rst) begin
      seen_key = 0; issue_now = 0; outstanding = 0; exp_err = 0;
      bq.delete(); exp_block = '0; exp_pad = 0; exp_blk = 0;
    end else begin
      if (dout_en && !outstanding) exp_err = 1;
      if (issue_now) begin
        issue_now = 0;
        outstanding = 1;
        exp_blk = exp_blk + 1;
      end else if (outstanding) begin
        if (dout_en) outstanding = 0;
      end else if (seen_key) begin
        if (key_ok && pix_valid) begin
          bq.push_back(pix);
          if (bq.size() == 16 || pix_last) begin
            for (int i = 0; i < 16; i++)
              exp_block[127-8*i -: 8] = (i < bq.size()) ? bq[i] : 8'h00;
            exp_pad = 5'(16 - bq.size());
            issue_now = 1;
            bq.delete();
          end
        end
      end else if (key_ok) begin
        seen_key = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready",   pix_ready, seen_key && !issue_now && !outstanding && key_ok);
      chk("din_en",  din_en, issue_now);
      chk("busy",    busy, outstanding);
      chk("err",     err, exp_err);
      chk("pad_cnt", pad_cnt, exp_pad);
      chk("blk_cnt", blk_cnt, exp_blk);
      chk("din_en_gap", din_en & prev_en, 1'b0);
      if (issue_now || outstanding) chk("din", din, exp_block);
      prev_en = din_en;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [7:0] b, input logic last);
    bit got = 0;
    pix_valid = 1; pix = b; pix_last = last;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (pix_ready) begin got = 1; break; end
    end
    if (!got) chk("send_timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
    pix_valid = 0; pix_last = 0;
  endtask

  task automatic wait_issue(output int n_cyc);
    n_cyc = -1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (din_en) begin n_cyc = n; break; end
    end
    if (n_cyc < 0) chk("issue_timeout", 1'b0, 1'b1);
  endtask

  task automatic release_blk();
    dout_en = 1; step(); dout_en = 0;
  endtask

  int lat;

  initial begin
    rst = 1; key_ok = 0; pix = 8'h55; pix_valid = 1; pix_last = 0; dout_en = 0;
    prev_en = 0;
    step(); step();
    chk_en = 1;
    rst = 0;
    // Key not ready: nothing accepted despite valid data
    repeat (5) step();
    @(negedge clk);
    chk("rst_ready", pix_ready, 1'b0);
    chk("rst_din", din, 128'h0);
    chk("rst_pad", pad_cnt, 5'd0);
    chk("rst_blk", blk_cnt, 32'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
    step();
    key_ok = 1; pix_valid = 0;
    step();
    @(negedge clk);
    chk("ready_rise", pix_ready, 1'b1);
    step();

    // Full block of 00..0F
    for (int i = 0; i < 16; i++) send(8'(i), 1'b0);
    wait_issue(lat);
    chk("lat_full", lat, 0);
    chk("blk1_din", din, 128'h000102030405060708090a0b0c0d0e0f);
    chk("blk1_pad", pad_cnt, 5'd0);
    step();
    chk("blk1_cnt", blk_cnt, 32'd1);
    chk("blk1_busy", busy, 1'b1);

    // Busy: held valid data must not be taken
    pix_valid = 1; pix = 8'hEE;
    repeat (3) step();
    @(negedge clk);
    chk("busy_ready", pix_ready, 1'b0);
    step();
    pix_valid = 0;
    release_blk();
    for (int i = 0; i < 16; i++) send(8'h10 + 8'(i), 1'b0);
    wait_issue(lat);
    chk("blk2_din", din, 128'h101112131415161718191a1b1c1d1e1f);
    step();
    chk("blk2_cnt", blk_cnt, 32'd2);
    release_blk();

    // Unqualified last is ignored, then a 3-byte short block
    pix_last = 1; step(); step(); pix_last = 0;
    send(8'hAA, 0); send(8'hBB, 0); send(8'hCC, 1);
    wait_issue(lat);
    chk("short_din", din, 128'hAABBCC00000000000000000000000000);
    chk("short_pad", pad_cnt, 5'd13);
    step();
    release_blk();

    // Stray dout_en in FILL: sticky error, packing continues
    send(8'h01, 0); send(8'h02, 0);
    dout_en = 1; step(); dout_en = 0;
    @(negedge clk);
    chk("err_fill", err, 1'b1);
    step();
    for (int i = 3; i <= 16; i++) send(8'(i), 1'b0);
    wait_issue(lat);
    chk("err_blk_din", din, 128'h0102030405060708090a0b0c0d0e0f10);
    step();
    release_blk();

    // Reset mid-fill
    send(8'h77, 0); send(8'h78, 0); send(8'h79, 0);
    rst = 1; step(); rst = 0;
    @(negedge clk);
    chk("mid_rst_din", din, 128'h0);
    chk("mid_rst_blk", blk_cnt, 32'd0);
    chk("mid_rst_err", err, 1'b0);
    chk("mid_rst_pad", pad_cnt, 5'd0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_ready", pix_ready, 1'b0);
    step();

    // Single-byte image, with dout_en landing in the ISSUE cycle
    send(8'h42, 1);
    wait_issue(lat);
    chk("single_pad", pad_cnt, 5'd15);
    chk("single_din", din, 128'h42000000000000000000000000000000);
    dout_en = 1;
    @(posedge clk); #1; dout_en = 0;
    @(negedge clk);
    chk("issue_err", err, 1'b1);
    chk("issue_busy", busy, 1'b1);
    step();
    release_blk();

    // key_ok dropout after 5 bytes
    for (int i = 0; i < 5; i++) send(8'hA0 + 8'(i), 1'b0);
    key_ok = 0; pix_valid = 1; pix = 8'h99;
    repeat (4) step();
    @(negedge clk);
    chk("stall_ready", pix_ready, 1'b0);
    step();
    key_ok = 1; pix_valid = 0;
    for (int i = 5; i < 16; i++) send(8'hA0 + 8'(i), 1'b0);
    wait_issue(lat);
    chk("stall_din", din, 128'ha0a1a2a3a4a5a6a7a8a9aaabacadaeaf);
    step();
    release_blk();

    // Last on the 16th byte: full block, no padding
    for (int i = 0; i < 16; i++) send(8'hC0 + 8'(i), i == 15);
    wait_issue(lat);
    chk("last16_pad", pad_cnt, 5'd0);
    chk("last16_din", din, 128'hc0c1c2c3c4c5c6c7c8c9cacbcccdcecf);
    step();
    chk("last16_cnt", blk_cnt, 32'd3);
    release_blk();
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
